sig_analyzer: RTL and testbench
===============================

# sig_analyzer

Serial signature analyzer sitting directly downstream of a single-output circuit-under-test wrapper: it consumes the wrapper's 1-bit output stream and compacts it into a CRC-style signature (MISR). A start/busy/done handshake sequences each capture window. A programmable skip window absorbs the circuit's pipeline latency. At the end of each window the signature is compared against a golden value.

## Interface
- WIDTH, 16: signature register width (≥2).
- POLY, 16'h1021: feedback polynomial, WIDTH bits; bit i set = XOR tap into bit i.
- SEED, 16'hFFFF: signature value loaded on accepted start.
- GOLDEN, 16'h0000: expected signature for pass.
- LATENCY, 1: samples discarded after start before capture begins (0 allowed).
- COUNT_W, 16: width of sample counter.

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a capture window; sampled only in IDLE.
- num_samples  in  COUNT_W  number of bits to compact; latched when start is accepted.
- din  in  1  serial output bit from the circuit under test.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse in DONE state.
- signature  out  WIDTH  current signature register.
- pass  out  1  signature == GOLDEN, registered in DONE, held until next accepted start.

## Operation
- States: IDLE, SKIP, CAPTURE, DONE.
- Reset (rst=1 at an edge, any state, including mid-window): state=IDLE, signature=0, pass=0, busy=0, done=0, counters=0. rst overrides start.
- IDLE: start=1 accepts. Latch N=num_samples, signature←SEED, pass←0, counter←0. Next state:
  - DONE if N==0.
  - else SKIP if LATENCY>0.
  - else CAPTURE.
- SKIP: din ignored; counter increments each cycle. After LATENCY cycles, counter←0 and go to CAPTURE.
- CAPTURE: each cycle, fb = signature[WIDTH-1] ^ din; signature ← {signature[WIDTH-2:0],1'b0} ^ (fb ? POLY : 0). Counter increments. After the N-th sample, go to DONE.
- DONE: done=1, pass ← (signature==GOLDEN), signature frozen. Next state is IDLE.
- start is ignored in SKIP, CAPTURE and DONE; there is no queuing.
- signature holds its value in IDLE and is modified only in CAPTURE (or by reset/start).
- Counter width is COUNT_W; N up to 2^COUNT_W−1 with no wrap before the terminal compare.
- din with X/Z is not permitted during CAPTURE.

## Timing
- Start accepted at edge T (state IDLE, start=1).
- For N>0: din sampled at edges T+1+LATENCY … T+LATENCY+N.
- done=1 and pass valid during cycle after edge T+LATENCY+N+1; i.e., done asserted in the cycle following the last sample.
- For N==0: done=1 in the cycle after edge T+1 (skip window bypassed); signature=SEED.
- busy high from edge T+1 through the DONE cycle inclusive; falls with done.
- Earliest next accepted start is at the edge that leaves DONE+1 (first IDLE cycle).
- Total window = LATENCY+N+1 cycles of busy.
- Latency to pass: combinational compare registered in DONE; pass updates at the same edge done rises.

## Test plan
- Reset: hold rst 2 cycles with start=1 → busy=0, done=0, signature=16'h0000, pass=0; no window starts.
- Single zero: LATENCY=1, start with N=1, din=0 at the capture edge → signature=16'hEFDF, done pulses exactly once, 3 busy cycles.
- Two ones: N=2, din=1,1 → signature 16'hFFFE then 16'hFFFC. With GOLDEN=16'hFFFC, pass=1 held after done.
- Zero-length: N=0 → done in the cycle after start, signature=16'hFFFF, pass=0 for GOLDEN=0.
- Skip window honored: LATENCY=1, N=1, din=1 during the skip cycle then 0 at capture → 16'hEFDF (skip bit ignored). A start pulse mid-window is ignored and busy stays unchanged.
- Mid-window reset: assert rst in CAPTURE after 3 of 8 samples → next edge IDLE, signature=0, no done pulse. A fresh start then completes normally with the correct signature.

Source files
------------

// File: rtl/sig_analyzer.sv
// -----------------------------------------------------------------------------
// sig_analyzer
//
// Serial signature analyzer (MISR) that compacts the 1-bit output stream of a
// circuit under test into a CRC-style signature. Each capture window is
// sequenced by a start/busy/done handshake:
//   IDLE -> SKIP (LATENCY cycles, din ignored) -> CAPTURE (N samples) -> DONE
// A zero-length request (N == 0) goes straight from IDLE to DONE. In the DONE
// cycle the signature is compared against GOLDEN, and the result is held on
// pass until the next accepted start.
//
// Ports
//   clk          single clock, all state updates on the rising edge
//   rst          synchronous, active-high reset (overrides start)
//   start        request a capture window, sampled only in IDLE
//   num_samples  number of bits to compact, latched when start is accepted
//   din          serial output bit from the circuit under test
//   busy         high whenever the analyzer is not IDLE
//   done         one-cycle pulse in the DONE state
//   signature    current signature register
//   pass         signature == GOLDEN, valid from the done pulse onwards
// -----------------------------------------------------------------------------
module sig_analyzer #(
  parameter int                 WIDTH   = 16,
  parameter logic [WIDTH-1:0]   POLY    = 16'h1021,
  parameter logic [WIDTH-1:0]   SEED    = 16'hFFFF,
  parameter logic [WIDTH-1:0]   GOLDEN  = 16'h0000,
  parameter int                 LATENCY = 1,
  parameter int                 COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COUNT_W-1:0] num_samples,
  input  logic               din,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   signature,
  output logic               pass
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SKIP,
    S_CAPTURE,
    S_DONE
  } state_t;

  // Terminal count of the skip window; never reached when LATENCY is 0
  // because SKIP is bypassed in that case.
  localparam logic [COUNT_W-1:0] LAT_LAST =
    COUNT_W'((LATENCY == 0) ? 0 : LATENCY - 1);

  state_t             state;
  logic [COUNT_W-1:0] cnt;
  logic [COUNT_W-1:0] n_lat;
  logic [WIDTH-1:0]   sig_next;
  logic               fb;

  // One MISR step: shift left, fold the feedback bit in through POLY.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first so no
    // path can leave it unassigned and infer a latch.
    fb       = 1'b0;
    sig_next = signature;
    fb       = signature[WIDTH-1] ^ din;
    sig_next = {signature[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      signature <= '0;
      pass      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cnt       <= '0;
      n_lat     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            n_lat     <= num_samples;
            signature <= SEED;
            cnt       <= '0;
            busy      <= 1'b1;
            if (num_samples == '0) begin
              // Empty window: the seed itself is the final signature.
              state <= S_DONE;
              done  <= 1'b1;
              pass  <= (SEED == GOLDEN);
            end else begin
              pass  <= 1'b0;
              state <= (LATENCY > 0) ? S_SKIP : S_CAPTURE;
            end
          end
        end

        S_SKIP: begin
          if (cnt == LAT_LAST) begin
            cnt   <= '0;
            state <= S_CAPTURE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_CAPTURE: begin
          signature <= sig_next;
          if (cnt == n_lat - 1'b1) begin
            // Last sample: pass is registered together with the done pulse,
            // from the signature value being written on this edge.
            cnt   <= '0;
            state <= S_DONE;
            done  <= 1'b1;
            pass  <= (sig_next == GOLDEN);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sig_analyzer.sv
// -----------------------------------------------------------------------------
// tb_sig_analyzer
//
// Directed testbench for sig_analyzer with LATENCY = 1 and GOLDEN = 16'hFFFC.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
// -----------------------------------------------------------------------------
module tb_sig_analyzer;

  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] num_samples;
  logic        din;
  logic        busy;
  logic        done;
  logic [15:0] signature;
  logic        pass;

  int n_checks = 0;
  int n_fail   = 0;

  // Results of the most recent run_window call.
  int          w_busy;
  int          w_done;
  logic [15:0] w_sig;
  logic        w_pass;
  logic        w_timeout;
  logic [15:0] w_trace [0:31];

  sig_analyzer #(
    .WIDTH   (16),
    .POLY    (16'h1021),
    .SEED    (16'hFFFF),
    .GOLDEN  (16'hFFFC),
    .LATENCY (LAT),
    .COUNT_W (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_samples (num_samples),
    .din         (din),
    .busy        (busy),
    .done        (done),
    .signature   (signature),
    .pass        (pass)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one window starting from an IDLE cycle. bits[i] is the i-th captured
  // sample, skip_din is driven during the skip window, mid_start keeps start
  // high while the window is in progress. Returns at the first IDLE cycle
  // after the window, without advancing past it.
  task automatic run_window(input int n, input logic [15:0] bits,
                            input logic skip_din, input logic mid_start);
    int c;
    int idx;
    w_busy    = 0;
    w_done    = 0;
    w_sig     = 'x;
    w_pass    = 'x;
    w_timeout = 1'b1;
    for (int i = 0; i < 32; i++) w_trace[i] = 'x;
    start       = 1'b1;
    num_samples = 16'(n);
    din         = 1'b0;
    step();
    start = mid_start;
    for (c = 0; c < n + 10; c++) begin
      if (c < 32) w_trace[c] = signature;
      if (!busy) begin
        w_timeout = 1'b0;
        break;
      end
      w_busy++;
      if (done) begin
        w_done++;
        w_sig  = signature;
        w_pass = pass;
      end
      idx = c - LAT;
      din = (idx >= 0 && idx < 16) ? bits[idx] : skip_din;
      step();
    end
    start = 1'b0;
    din   = 1'b0;
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    start       = 1'b1;
    num_samples = 16'd5;
    din         = 1'b1;
    step();
    step();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++;
    if (signature !== 16'h0000) begin n_fail++; $display("FAIL reset_sig: got %h want 0000", signature); end
    n_checks++;
    if (pass !== 1'b0) begin n_fail++; $display("FAIL reset_pass: got %b want 0", pass); end
    rst   = 1'b0;
    start = 1'b0;
    din   = 1'b0;
    step();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_no_window: busy %b want 0", busy); end
  endtask

  task automatic test_single_zero();
    run_window(1, 16'h0000, 1'b0, 1'b0);
    n_checks++;
    if (w_timeout) begin n_fail++; $display("FAIL single_zero_timeout: window never ended"); end
    n_checks++;
    if (w_sig !== 16'hEFDF) begin n_fail++; $display("FAIL single_zero_sig: got %h want efdf", w_sig); end
    n_checks++;
    if (w_done !== 1) begin n_fail++; $display("FAIL single_zero_done: got %0d pulses want 1", w_done); end
    n_checks++;
    if (w_busy !== 3) begin n_fail++; $display("FAIL single_zero_busy: got %0d cycles want 3", w_busy); end
    n_checks++;
    if (w_pass !== 1'b0) begin n_fail++; $display("FAIL single_zero_pass: got %b want 0", w_pass); end
    n_checks++;
    if (signature !== 16'hEFDF) begin n_fail++; $display("FAIL single_zero_hold: got %h want efdf", signature); end
  endtask

  task automatic test_two_ones();
    run_window(2, 16'h0003, 1'b0, 1'b0);
    n_checks++;
    if (w_trace[2] !== 16'hFFFE) begin n_fail++; $display("FAIL two_ones_first: got %h want fffe", w_trace[2]); end
    n_checks++;
    if (w_sig !== 16'hFFFC) begin n_fail++; $display("FAIL two_ones_sig: got %h want fffc", w_sig); end
    n_checks++;
    if (w_pass !== 1'b1) begin n_fail++; $display("FAIL two_ones_pass: got %b want 1", w_pass); end
    n_checks++;
    if (w_busy !== 4) begin n_fail++; $display("FAIL two_ones_busy: got %0d cycles want 4", w_busy); end
    step();
    step();
    n_checks++;
    if (pass !== 1'b1) begin n_fail++; $display("FAIL two_ones_pass_held: got %b want 1", pass); end
  endtask

  task automatic test_zero_length();
    run_window(0, 16'h0000, 1'b0, 1'b0);
    n_checks++;
    if (w_trace[0] !== 16'hFFFF || w_done !== 1) begin
      n_fail++;
      $display("FAIL zero_len_done: sig %h done %0d want ffff 1", w_trace[0], w_done);
    end
    n_checks++;
    if (w_busy !== 1) begin n_fail++; $display("FAIL zero_len_busy: got %0d cycles want 1", w_busy); end
    n_checks++;
    if (w_pass !== 1'b0) begin n_fail++; $display("FAIL zero_len_pass: got %b want 0", w_pass); end
  endtask

  task automatic test_skip_window();
    // Skip-cycle bit is 1 and must be ignored; start stays high mid-window.
    run_window(1, 16'h0000, 1'b1, 1'b1);
    n_checks++;
    if (w_sig !== 16'hEFDF) begin n_fail++; $display("FAIL skip_sig: got %h want efdf", w_sig); end
    n_checks++;
    if (w_busy !== 3 || w_done !== 1) begin
      n_fail++;
      $display("FAIL skip_mid_start: busy %0d done %0d want 3 1", w_busy, w_done);
    end
    step();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL skip_no_requeue: busy %b want 0", busy); end
  endtask

  task automatic test_mid_reset();
    logic saw_done;
    saw_done    = 1'b0;
    start       = 1'b1;
    num_samples = 16'd8;
    step();
    start = 1'b0;
    din   = 1'b0;
    step();                      // skip cycle
    for (int i = 0; i < 3; i++) begin
      din = 1'b1;
      step();                    // capture edges
      if (done) saw_done = 1'b1;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || signature !== 16'h0000) begin
      n_fail++;
      $display("FAIL mid_reset_state: busy %b sig %h want 0 0000", busy, signature);
    end
    for (int i = 0; i < 8; i++) begin
      if (done) saw_done = 1'b1;
      step();
    end
    n_checks++;
    if (saw_done !== 1'b0) begin n_fail++; $display("FAIL mid_reset_no_done: saw done pulse"); end
    run_window(3, 16'h0005, 1'b0, 1'b0);
    n_checks++;
    if (w_sig !== 16'hDFBA || w_pass !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_fresh: sig %h pass %b want dfba 0", w_sig, w_pass);
    end
  endtask

  task automatic test_back_to_back();
    run_window(1, 16'h0001, 1'b0, 1'b0);
    n_checks++;
    if (w_sig !== 16'hFFFE) begin n_fail++; $display("FAIL b2b_first: got %h want fffe", w_sig); end
    // Start issued in the very first IDLE cycle.
    run_window(2, 16'h0003, 1'b0, 1'b0);
    n_checks++;
    if (w_sig !== 16'hFFFC || w_pass !== 1'b1 || w_busy !== 4) begin
      n_fail++;
      $display("FAIL b2b_second: sig %h pass %b busy %0d want fffc 1 4", w_sig, w_pass, w_busy);
    end
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    num_samples = '0;
    din         = 1'b0;
    test_reset();
    test_single_zero();
    test_two_ones();
    test_zero_length();
    test_skip_window();
    test_mid_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
